// File: rtl/poly_pkg.sv
// rtl/poly_pkg.sv - shared state encoding and parameter bounds for the Horner evaluator
package poly_pkg;

    localparam int WIDTH_MIN  = 4;
    localparam int WIDTH_MAX  = 32;
    localparam int DEGREE_MIN = 1;
    localparam int DEGREE_MAX = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/poly_ula.sv
// rtl/poly_ula.sv - combinational signed add/multiply unit with wrap and overflow detection
module poly_ula #(
    parameter int WIDTH = 16
) (
    input  logic signed [WIDTH-1:0] op_a,
    input  logic signed [WIDTH-1:0] op_b,
    input  logic                    h,
    output logic signed [WIDTH-1:0] result,
    output logic                    overflow
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   sum;
    logic        [WIDTH:0]     prod_top;

    always_comb begin
        prod     = (2*WIDTH)'(op_a) * (2*WIDTH)'(op_b);
        sum      = op_a + op_b;
        // The product fits only if its upper WIDTH+1 bits are a pure sign extension.
        prod_top = prod[2*WIDTH-1:WIDTH-1];
        result   = sum;
        overflow = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        if (h) begin
            result   = prod[WIDTH-1:0];
            overflow = !((&prod_top) || !(|prod_top));
        end
    end

endmodule

// File: rtl/poly_horner.sv
// rtl/poly_horner.sv - sequential Horner-rule polynomial evaluator using one shared ALU
module poly_horner
    import poly_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEGREE = 2
) (
    input  logic                          ck,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [WIDTH-1:0]       x,
    input  logic [(DEGREE+1)*WIDTH-1:0]   coef,
    output logic                          busy,
    output logic                          done,
    output logic signed [WIDTH-1:0]       resultado,
    output logic                          overflow
);

    localparam int IW    = $clog2(DEGREE + 1);
    localparam int SLOTS = 1 << IW;
    localparam int CW    = SLOTS * WIDTH;

    state_t state, state_nxt;

    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] xr;
    logic [CW-1:0]           coef_q;
    logic [CW-1:0]           coef_pad;
    logic [WIDTH-1:0]        words [SLOTS];
    logic [IW-1:0]           idx;
    logic                    sticky;

    logic                    ula_h;
    logic signed [WIDTH-1:0] ula_b;
    logic signed [WIDTH-1:0] ula_res;
    logic                    ula_ovf;

    // Pad the coefficient vector to a power-of-two slot count so idx never selects past the array.
    assign coef_pad = CW'(coef);

    for (genvar i = 0; i < SLOTS; i++) begin : g_words
        assign words[i] = coef_q[i*WIDTH +: WIDTH];
    end

    assign ula_h = (state == MUL);
    assign ula_b = ula_h ? xr : words[idx];

    poly_ula #(.WIDTH(WIDTH)) u_ula (
        .op_a     (acc),
        .op_b     (ula_b),
        .h        (ula_h),
        .result   (ula_res),
        .overflow (ula_ovf)
    );

    always_ff @(posedge ck) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = MUL;
            MUL: begin
                busy      = 1'b1;
                state_nxt = ADD;
            end
            ADD: begin
                busy      = 1'b1;
                state_nxt = (idx == '0) ? DONE : MUL;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ck) begin
        if (!rst) begin
            acc       <= '0;
            xr        <= '0;
            coef_q    <= '0;
            idx       <= '0;
            sticky    <= 1'b0;
            resultado <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        xr     <= x;
                        coef_q <= coef_pad;
                        acc    <= coef[DEGREE*WIDTH +: WIDTH];
                        idx    <= IW'(DEGREE - 1);
                        sticky <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= ula_res;
                    sticky <= sticky | ula_ovf;
                end
                ADD: begin
                    acc    <= ula_res;
                    sticky <= sticky | ula_ovf;
                    if (idx == '0) begin
                        resultado <= ula_res;
                        overflow  <= sticky | ula_ovf;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_horner.sv
// tb/tb_poly_horner.sv - scoreboard bench for poly_horner against a plain-arithmetic reference
module tb_poly_horner;

    logic        ck = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] x;
    logic [47:0] coef;
    logic        busy, done, ovf;
    logic [15:0] res;

    logic        start2;
    logic [7:0]  x2;
    logic [31:0] coef2;
    logic        busy2, done2, ovf2;
    logic [7:0]  res2;

    always #5 ck = ~ck;

    poly_horner #(.WIDTH(16), .DEGREE(2)) dut (
        .ck(ck), .rst(rst), .start(start), .x(x), .coef(coef),
        .busy(busy), .done(done), .resultado(res), .overflow(ovf)
    );

    poly_horner #(.WIDTH(8), .DEGREE(3)) dut2 (
        .ck(ck), .rst(rst), .start(start2), .x(x2), .coef(coef2),
        .busy(busy2), .done(done2), .resultado(res2), .overflow(ovf2)
    );

    typedef struct packed {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          dones    = 0;
    logic [15:0] last_res;
    logic        last_ovf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic longint wrap(input longint v, input int w);
        longint m, r;
        m = longint'(1) << w;
        r = v & (m - 1);
        if (r >= m / 2) r = r - m;
        return r;
    endfunction

    // p(x) by Horner's rule in wide integers; any step leaving the signed w-bit range is an overflow.
    function automatic void model(input int w, input int n, input longint xv, input longint c[9],
                                  output longint r, output bit o);
        longint lo, hi, acc, t;
        lo  = -(longint'(1) << (w - 1));
        hi  = (longint'(1) << (w - 1)) - 1;
        acc = c[n];
        o   = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            t = acc * xv;
            if (t < lo || t > hi) o = 1'b1;
            acc = wrap(t, w);
            t = acc + c[i];
            if (t < lo || t > hi) o = 1'b1;
            acc = wrap(t, w);
        end
        r = acc;
    endfunction

    always @(negedge ck) begin : monitor
        exp_t e;
        if (rst && done === 1'b1) begin
            dones++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0");
            end else begin
                e = sb.pop_front();
                check("sb_result", 32'(res), 32'(e.res));
                check("sb_overflow", 32'(ovf), 32'(e.ovf));
            end
        end
    end

    task automatic run(input longint xv, input longint c0, input longint c1, input longint c2,
                       input bit intrude, input int abort_at);
        longint c[9];
        longint er;
        bit     eo;
        int     cnt, bcnt, d0;
        c = '{default: 0};
        c[0] = c0; c[1] = c1; c[2] = c2;
        model(16, 2, xv, c, er, eo);
        @(negedge ck);
        start = 1'b1;
        x     = xv[15:0];
        coef  = {c2[15:0], c1[15:0], c0[15:0]};
        d0    = dones;
        @(posedge ck);
        if (abort_at == 0) sb.push_back('{er[15:0], eo});
        #1;
        start = 1'b0;
        x     = 16'($urandom);
        coef  = 48'({$urandom(), $urandom()});
        cnt   = 0;
        bcnt  = 0;
        while (cnt < 40) begin
            @(negedge ck);
            cnt++;
            if (cnt == 1) begin
                check("hold_result", 32'(res), 32'(last_res));
                check("hold_overflow", 32'(ovf), 32'(last_ovf));
            end
            if (abort_at != 0 && cnt == abort_at + 1) begin
                check("abort_busy", 32'(busy), 0);
                check("abort_done", 32'(done), 0);
                check("abort_result", 32'(res), 0);
                check("abort_overflow", 32'(ovf), 0);
                rst      = 1'b1;
                last_res = '0;
                last_ovf = 1'b0;
                @(negedge ck);
                check("abort_no_done", 32'(dones - d0), 0);
                return;
            end
            if (abort_at != 0 && cnt == abort_at) rst = 1'b0;
            if (intrude && (cnt == 2 || cnt == 3)) begin
                start = 1'b1;
                x     = 16'($urandom);
            end else begin
                start = 1'b0;
            end
            if (busy) bcnt++;
            if (done) break;
        end
        check("latency", 32'(cnt), 5);
        check("busy_cycles", 32'(bcnt), 4);
        @(negedge ck);
        check("idle_after_done", 32'({busy, done}), 0);
        check("done_pulses", 32'(dones - d0), 1);
        last_res = er[15:0];
        last_ovf = eo;
    endtask

    task automatic run8(input longint xv, input longint c[9]);
        longint er;
        bit     eo;
        int     cnt;
        model(8, 3, xv, c, er, eo);
        @(negedge ck);
        start2 = 1'b1;
        x2     = xv[7:0];
        coef2  = {c[3][7:0], c[2][7:0], c[1][7:0], c[0][7:0]};
        @(posedge ck);
        #1;
        start2 = 1'b0;
        x2     = 8'($urandom);
        cnt    = 0;
        while (cnt < 40) begin
            @(negedge ck);
            cnt++;
            if (done2) break;
        end
        check("d3_latency", 32'(cnt), 7);
        check("d3_result", 32'(res2), 32'(er[7:0]));
        check("d3_overflow", 32'(ovf2), 32'(eo));
    endtask

    function automatic longint rnd(input int w);
        if ($urandom_range(0, 1) == 0) return longint'($urandom_range(0, 20)) - 10;
        return longint'($urandom_range(0, (1 << w) - 1)) - (longint'(1) << (w - 1));
    endfunction

    initial begin
        longint c[9];
        rst    = 1'b0;
        start  = 1'b1;
        x      = 16'd5;
        coef   = 48'h0001_0002_0003;
        start2 = 1'b0;
        x2     = '0;
        coef2  = '0;
        repeat (3) @(negedge ck);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_result", 32'(res), 0);
        check("reset_overflow", 32'(ovf), 0);
        start    = 1'b0;
        rst      = 1'b1;
        last_res = '0;
        last_ovf = 1'b0;

        run(3, 7, 5, 2, 1'b0, 0);
        check("basic_40", 32'(res), 40);
        run(-2, -1, 0, 1, 1'b0, 0);
        check("neg_x_3", 32'(res), 3);
        run(300, 0, 0, 1, 1'b0, 0);
        check("mul_wrap_result", 32'(res), 24464);
        check("mul_wrap_overflow", 32'(ovf), 1);
        run(1, 1, 0, 0, 1'b0, 0);
        check("sticky_cleared_result", 32'(res), 1);
        check("sticky_cleared_overflow", 32'(ovf), 0);
        run(5, 3, -4, 9, 1'b1, 0);
        run(7, 1, 2, 3, 1'b0, 3);
        run(3, 7, 5, 2, 1'b0, 0);
        check("after_abort_40", 32'(res), 40);
        for (int i = 0; i < 30; i++) begin
            run(rnd(16), rnd(16), rnd(16), rnd(16), i[0], 0);
        end

        c = '{default: 0};
        c[0] = 1; c[1] = 1; c[2] = 1; c[3] = 1;
        run8(2, c);
        check("d3_15", 32'(res2), 15);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 4; k++) c[k] = rnd(8);
            run8(rnd(8), c);
        end

        repeat (3) @(negedge ck);
        check("scoreboard_drained", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
